// File: rtl/flop_r.sv
// ---------------------------------------------------------------------------
// flop_r : N-bit D-type register with synchronous, active-high reset.
//
// This is the leaf state element used for pipeline registers, the program
// counter and datapath state. Enable and multi-stage variants are built on it.
//
// Parameters
//   N          data width of d and q (N >= 1)
//   RESET_VAL  value loaded into q while reset is high (default all zeros)
//
// Ports (positional order is fixed: existing instances connect by position)
//   clk    rising-edge clock, the only timing reference
//   reset  synchronous reset, active-high, sampled on the rising clk edge
//   d      data input, sampled on the rising clk edge
//   q      registered output, one clock of latency from d
//
// There is no combinational path from d to q. q is left uninitialised, so
// it reads X in simulation until the first rising edge.
// ---------------------------------------------------------------------------
module flop_r #(
  parameter int            N         = 64,
  parameter logic [N-1:0]  RESET_VAL = '0
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [N-1:0] d,
  output logic [N-1:0] q
);

  // reset is left out of the sensitivity list, so it only takes effect on a
  // clock edge. It also wins over d at that edge. The nonblocking update
  // lets chained instances behave as a proper shift pipeline.
  always_ff @(posedge clk) begin
    if (reset) begin
      q <= RESET_VAL;
    end else begin
      q <= d;
    end
  end

endmodule

// File: tb/tb_flop_r.sv
module tb_flop_r;

  logic        clk;
  logic        reset;
  logic [63:0] d;
  logic [63:0] q;

  logic        reset8;
  logic [7:0]  d8;
  logic [7:0]  q8;

  int tests_run;
  int tests_failed;

  // Default instance: N=64, RESET_VAL=0
  flop_r dut (
    .clk   (clk),
    .reset (reset),
    .d     (d),
    .q     (q)
  );

  // Narrow instance with a non-zero reset value
  flop_r #(.N(8), .RESET_VAL(8'hA5)) dut8 (
    .clk   (clk),
    .reset (reset8),
    .d     (d8),
    .q     (q8)
  );

  // 20 ns period: rising edges at 10, 30, 50, ...
  initial clk = 1'b0;
  always #10 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, got, exp);
    end else begin
      $display("[TB] ok   %s: %h", tag, got);
    end
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    reset  = 1'b1;
    d      = 64'd0;
    reset8 = 1'b1;
    d8     = 8'hFF;

    // Reset hold: q stays 0 at every negedge while reset is high
    for (int i = 0; i < 3; i++) begin
      d = 64'(i);
      @(negedge clk);
      check($sformatf("reset_hold[%0d]", i), q, 64'd0);
    end
    check("reset8_val", {56'd0, q8}, 64'h00000000000000A5);

    // Reset precedence: all-ones and X on d are ignored while reset is high
    d = '1;
    @(negedge clk);
    check("reset_over_ones", q, 64'd0);
    d = 'x;
    @(negedge clk);
    check("reset_over_x", q, 64'd0);

    // Load after release: d applied 1 ns after a posedge
    @(posedge clk);
    #1;
    reset = 1'b0;
    d     = 64'd5;
    @(negedge clk);
    check("pre_load", q, 64'd0);
    @(posedge clk);
    @(negedge clk);
    check("load_5", q, 64'd5);

    // Sequence 0..9, one value per cycle, checked one cycle later
    for (int i = 0; i < 10; i++) begin
      d = 64'(i);
      @(negedge clk);
      check($sformatf("seq[%0d]", i), q, 64'(i));
    end

    // Mid-cycle glitch on d: q must only follow d at the edge
    @(posedge clk);
    #1 d = 64'd7;
    #2 d = 64'd3;
    #1 check("glitch_mid", q, 64'd9);
    #1 d = 64'd7;
    @(negedge clk);
    check("glitch_pre_edge", q, 64'd9);
    @(posedge clk);
    #1 check("glitch_post_edge", q, 64'd7);

    // Reset mid-operation: no asynchronous clear
    @(negedge clk);
    d = 64'd9;
    @(posedge clk);
    #1 check("pre_midreset", q, 64'd9);
    #4 reset = 1'b1;
    #1 check("midreset_async", q, 64'd9);
    @(negedge clk);
    check("midreset_hold", q, 64'd9);
    @(posedge clk);
    #1 check("midreset_cleared", q, 64'd0);
    @(negedge clk);
    reset = 1'b0;
    d     = 64'd12;
    @(posedge clk);
    #1 check("release_load", q, 64'd12);

    // Full-width data, no truncation
    @(negedge clk);
    d = 64'hDEAD_BEEF_0123_4567;
    @(negedge clk);
    check("full_width", q, 64'hDEAD_BEEF_0123_4567);
    d = 64'h8000_0000_0000_0001;
    @(negedge clk);
    check("msb_lsb", q, 64'h8000_0000_0000_0001);

    // Narrow instance: load, then reset to its non-zero value
    reset8 = 1'b0;
    d8     = 8'hFF;
    @(negedge clk);
    check("n8_ff", {56'd0, q8}, 64'h00000000000000FF);
    d8 = 8'h3C;
    @(negedge clk);
    check("n8_3c", {56'd0, q8}, 64'h000000000000003C);
    reset8 = 1'b1;
    @(negedge clk);
    check("n8_reset", {56'd0, q8}, 64'h00000000000000A5);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
